decision_trail: RTL and testbench

- Consumer end of the decision engine interface in the hardware BCP datapath.
- Drives decision_en and waits for decision_finish, then records each decided (variable, value) pair on a chronological trail stack.
- On a conflict it backtracks: pops exhausted decisions, then re-issues the most recent untried decision with its value negated.
- Reports decision level, SAT (no variable left) and UNSAT (conflict with nothing left to flip).

---
 rtl/decision_trail.sv | 245 ++++++++++++++++++++++++
 tb/tb_decision_trail.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decision_trail.sv
`default_nettype none
// ============================================================================
// Module   : decision_trail
// Brief    : Decision trail stack with chronological backtracking and flip.
//            Optional TRAIL_STATS_EN adds saturating decision/backtrack counts.
// Revision : 1.0
// ============================================================================
module decision_trail #(
    parameter int VAR_NUM    = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  conflict,
    output logic                  decision_en,
    input  logic [VAR_NUM-1:0]    var_in,
    input  logic                  assignment_in,
    input  logic                  decision_finish,
    output logic                  bt_valid,
    output logic [VAR_NUM-1:0]    bt_var,
    output logic                  flip_valid,
    output logic [VAR_NUM-1:0]    flip_var,
    output logic                  flip_value,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  busy,
    output logic                  sat,
    output logic                  unsat,
`ifdef TRAIL_STATS_EN
    output logic [15:0]           decision_count,
    output logic [15:0]           backtrack_count,
`endif
    output logic                  overflow
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_req  = 3'd1;
    localparam logic [2:0] c_st_bt   = 3'd2;
    localparam logic [2:0] c_st_flip = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;

    logic [VAR_NUM-1:0]      r_tr_var  [DEPTH];
    logic                    r_tr_val  [DEPTH];
    logic                    r_tr_flip [DEPTH];
    logic [ADDR_WIDTH:0]     r_level;

    logic                    r_decision_en;
    logic                    r_bt_valid;
    logic [VAR_NUM-1:0]      r_bt_var;
    logic                    r_flip_valid;
    logic [VAR_NUM-1:0]      r_flip_var;
    logic                    r_flip_value;
    logic                    r_sat;
    logic                    r_unsat;
    logic                    r_overflow;

    logic [ADDR_WIDTH-1:0]   w_top_idx;
    logic [ADDR_WIDTH-1:0]   w_push_idx;
    logic [VAR_NUM-1:0]      w_top_var;
    logic                    w_top_val;
    logic                    w_top_flip;
    logic                    w_level_zero;
    logic                    w_level_full;
    logic                    w_var_zero;

    logic                    w_push;
    logic                    w_set_sat;
    logic                    w_set_ovf;
    logic                    w_set_unsat;
    logic                    w_bt_fire;
    logic                    w_pop;
    logic                    w_flip_fire;

    // Top of trail is entry level-1; index is only consumed when level != 0.
    assign w_top_idx    = ADDR_WIDTH'(r_level - 1'b1);
    assign w_push_idx   = r_level[ADDR_WIDTH-1:0];
    assign w_top_var    = r_tr_var[w_top_idx];
    assign w_top_val    = r_tr_val[w_top_idx];
    assign w_top_flip   = r_tr_flip[w_top_idx];
    assign w_level_zero = (r_level == '0);
    assign w_level_full = (r_level == c_depth);
    assign w_var_zero   = (var_in == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (conflict) begin
                    w_next_state = c_st_bt;
                end else if (start) begin
                    w_next_state = c_st_req;
                end
            end
            c_st_req: begin
                if (conflict) begin
                    w_next_state = c_st_bt;
                end else if (decision_finish) begin
                    if (w_var_zero || w_level_full) begin
                        w_next_state = c_st_done;
                    end else begin
                        w_next_state = c_st_idle;
                    end
                end
            end
            c_st_bt: begin
                if (w_level_zero) begin
                    w_next_state = c_st_done;
                end else if (!w_top_flip) begin
                    w_next_state = c_st_flip;
                end
            end
            c_st_flip: w_next_state = c_st_idle;
            c_st_done: w_next_state = c_st_done;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_set_sat   = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unsat = 1'b0;
        w_bt_fire   = 1'b0;
        w_pop       = 1'b0;
        w_flip_fire = 1'b0;
        case (r_state)
            c_st_req: begin
                // A conflict in the same cycle discards the returned decision.
                if (!conflict && decision_finish) begin
                    w_set_sat = w_var_zero;
                    w_set_ovf = !w_var_zero && w_level_full;
                    w_push    = !w_var_zero && !w_level_full;
                end
            end
            c_st_bt: begin
                w_set_unsat = w_level_zero;
                w_bt_fire   = !w_level_zero;
                w_pop       = !w_level_zero && w_top_flip;
            end
            c_st_flip: w_flip_fire = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tr_var[i]  <= '0;
                r_tr_val[i]  <= 1'b0;
                r_tr_flip[i] <= 1'b0;
            end
            r_level       <= '0;
            r_decision_en <= 1'b0;
            r_bt_valid    <= 1'b0;
            r_bt_var      <= '0;
            r_flip_valid  <= 1'b0;
            r_flip_var    <= '0;
            r_flip_value  <= 1'b0;
            r_sat         <= 1'b0;
            r_unsat       <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_decision_en <= (w_next_state == c_st_req);
            r_bt_valid    <= w_bt_fire;
            r_bt_var      <= w_bt_fire ? w_top_var : '0;
            r_flip_valid  <= w_flip_fire;
            r_flip_var    <= w_flip_fire ? w_top_var : '0;
            r_flip_value  <= w_flip_fire ? ~w_top_val : 1'b0;

            if (w_push) begin
                r_tr_var[w_push_idx]  <= var_in;
                r_tr_val[w_push_idx]  <= assignment_in;
                r_tr_flip[w_push_idx] <= 1'b0;
                r_level               <= r_level + 1'b1;
            end
            if (w_pop) begin
                r_level <= r_level - 1'b1;
            end
            if (w_flip_fire) begin
                r_tr_val[w_top_idx]  <= ~w_top_val;
                r_tr_flip[w_top_idx] <= 1'b1;
            end

            if (w_set_sat) begin
                r_sat <= 1'b1;
            end
            if (w_set_unsat) begin
                r_unsat <= 1'b1;
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef TRAIL_STATS_EN
    logic [15:0] r_decision_count;
    logic [15:0] r_backtrack_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_decision_count  <= '0;
            r_backtrack_count <= '0;
        end else begin
            if (w_push && (r_decision_count != 16'hFFFF)) begin
                r_decision_count <= r_decision_count + 16'd1;
            end
            if (w_bt_fire && (r_backtrack_count != 16'hFFFF)) begin
                r_backtrack_count <= r_backtrack_count + 16'd1;
            end
        end
    end

    assign decision_count  = r_decision_count;
    assign backtrack_count = r_backtrack_count;
`endif

    assign decision_en = r_decision_en;
    assign bt_valid    = r_bt_valid;
    assign bt_var      = r_bt_var;
    assign flip_valid  = r_flip_valid;
    assign flip_var    = r_flip_var;
    assign flip_value  = r_flip_value;
    assign level       = r_level;
    assign busy        = (r_state != c_st_idle);
    assign sat         = r_sat;
    assign unsat       = r_unsat;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_decision_trail.sv
`default_nettype none
// ============================================================================
// Module   : tb_decision_trail
// Brief    : Self-checking bench for decision_trail against a queue-based
//            trail model; directed scenarios followed by random operations.
// Revision : 1.0
// ============================================================================
module tb_decision_trail;

    localparam int VAR_NUM    = 8;
    localparam int DEPTH      = 8;
    localparam int ADDR_WIDTH = 3;

    logic                  clock           = 1'b0;
    logic                  reset           = 1'b1;
    logic                  start           = 1'b0;
    logic                  conflict        = 1'b0;
    logic [VAR_NUM-1:0]    var_in          = '0;
    logic                  assignment_in   = 1'b0;
    logic                  decision_finish = 1'b0;
    logic                  decision_en;
    logic                  bt_valid;
    logic [VAR_NUM-1:0]    bt_var;
    logic                  flip_valid;
    logic [VAR_NUM-1:0]    flip_var;
    logic                  flip_value;
    logic [ADDR_WIDTH:0]   level;
    logic                  busy;
    logic                  sat;
    logic                  unsat;
    logic                  overflow;
`ifdef TRAIL_STATS_EN
    logic [15:0]           decision_count;
    logic [15:0]           backtrack_count;
`endif

    decision_trail #(
        .VAR_NUM    (VAR_NUM),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .conflict        (conflict),
        .decision_en     (decision_en),
        .var_in          (var_in),
        .assignment_in   (assignment_in),
        .decision_finish (decision_finish),
        .bt_valid        (bt_valid),
        .bt_var          (bt_var),
        .flip_valid      (flip_valid),
        .flip_var        (flip_var),
        .flip_value      (flip_value),
        .level           (level),
        .busy            (busy),
        .sat             (sat),
        .unsat           (unsat),
`ifdef TRAIL_STATS_EN
        .decision_count  (decision_count),
        .backtrack_count (backtrack_count),
`endif
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [VAR_NUM-1:0] v;
        logic               val;
        logic               fl;
    } entry_t;

    // Reference model: the trail as a queue of decisions plus sticky flags.
    entry_t              m_q[$];
    bit                  m_sat, m_unsat, m_ovf, m_done;
    logic [VAR_NUM-1:0]  exp_bt[$];
    bit                  exp_flip;
    logic [VAR_NUM-1:0]  exp_fvar;
    logic                exp_fval;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        m_q.delete();
        m_sat   = 1'b0;
        m_unsat = 1'b0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
    endfunction

    function automatic void model_decide(input logic [VAR_NUM-1:0] v, input logic a);
        entry_t e;
        if (m_done) return;
        if (v == '0) begin
            m_sat  = 1'b1;
            m_done = 1'b1;
        end else if (m_q.size() == DEPTH) begin
            m_ovf  = 1'b1;
            m_done = 1'b1;
        end else begin
            e.v   = v;
            e.val = a;
            e.fl  = 1'b0;
            m_q.push_back(e);
        end
    endfunction

    // Undo every already-flipped decision, then flip the newest untried one.
    function automatic void model_conflict();
        int t;
        exp_bt.delete();
        exp_flip = 1'b0;
        exp_fvar = '0;
        exp_fval = 1'b0;
        if (m_done) return;
        while (m_q.size() > 0 && m_q[m_q.size()-1].fl) begin
            exp_bt.push_back(m_q[m_q.size()-1].v);
            m_q.delete(m_q.size()-1);
        end
        if (m_q.size() == 0) begin
            m_unsat = 1'b1;
            m_done  = 1'b1;
        end else begin
            t = m_q.size() - 1;
            exp_bt.push_back(m_q[t].v);
            m_q[t].val = ~m_q[t].val;
            m_q[t].fl  = 1'b1;
            exp_flip   = 1'b1;
            exp_fvar   = m_q[t].v;
            exp_fval   = m_q[t].val;
        end
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_level"},    32'(level),       32'(m_q.size()));
        chk({tag, "_sat"},      32'(sat),         32'(m_sat));
        chk({tag, "_unsat"},    32'(unsat),       32'(m_unsat));
        chk({tag, "_overflow"}, 32'(overflow),    32'(m_ovf));
        chk({tag, "_busy"},     32'(busy),        32'(m_done));
        chk({tag, "_dec_en"},   32'(decision_en), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        chk({tag, "_rst_level"},  32'(level),       32'd0);
        chk({tag, "_rst_dec_en"}, 32'(decision_en), 32'd0);
        chk({tag, "_rst_busy"},   32'(busy),        32'd0);
        chk({tag, "_rst_pulses"}, 32'({bt_valid, flip_valid, bt_var, flip_var, flip_value}), 32'd0);
        chk({tag, "_rst_flags"},  32'({sat, unsat, overflow}), 32'd0);
        model_clear();
        #17;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic collect_and_check(input string tag);
        logic [VAR_NUM-1:0] obs_bt[$];
        int                 n_flip = 0;
        logic [VAR_NUM-1:0] o_fvar = '0;
        logic               o_fval = 1'b0;
        for (int c = 0; c < 2*DEPTH+4; c++) begin
            if (bt_valid) obs_bt.push_back(bt_var);
            if (flip_valid) begin
                n_flip++;
                o_fvar = flip_var;
                o_fval = flip_value;
            end
            @(negedge clock);
        end
        chk({tag, "_bt_count"}, 32'(obs_bt.size()), 32'(exp_bt.size()));
        for (int i = 0; i < exp_bt.size() && i < obs_bt.size(); i++)
            chk({tag, "_bt_var"}, 32'(obs_bt[i]), 32'(exp_bt[i]));
        chk({tag, "_flip_count"}, 32'(n_flip), exp_flip ? 32'd1 : 32'd0);
        if (exp_flip && n_flip == 1) begin
            chk({tag, "_flip_var"},   32'(o_fvar), 32'(exp_fvar));
            chk({tag, "_flip_value"}, 32'(o_fval), 32'(exp_fval));
        end
        check_status(tag);
    endtask

    task automatic decide(input logic [VAR_NUM-1:0] v, input logic a, input int lat);
        bit was_done;
        was_done = m_done;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("req_dec_en", 32'(decision_en), was_done ? 32'd0 : 32'd1);
        repeat (lat) begin
            @(negedge clock);
            chk("req_dec_en_hold", 32'(decision_en), was_done ? 32'd0 : 32'd1);
        end
        var_in          = v;
        assignment_in   = a;
        decision_finish = 1'b1;
        @(negedge clock);
        decision_finish = 1'b0;
        var_in          = '0;
        assignment_in   = 1'b0;
        model_decide(v, a);
        check_status("decide");
    endtask

    task automatic pulse_conflict(input string tag);
        @(negedge clock);
        conflict = 1'b1;
        @(negedge clock);
        conflict = 1'b0;
        model_conflict();
        collect_and_check(tag);
    endtask

    task automatic req_conflict(input string tag, input bit with_finish, input logic [VAR_NUM-1:0] v);
        bit was_done;
        was_done = m_done;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_dec_en"}, 32'(decision_en), was_done ? 32'd0 : 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        conflict        = 1'b1;
        decision_finish = with_finish;
        var_in          = v;
        assignment_in   = 1'b1;
        @(negedge clock);
        conflict        = 1'b0;
        decision_finish = 1'b0;
        var_in          = '0;
        assignment_in   = 1'b0;
        chk({tag, "_dec_en_drop"}, 32'(decision_en), 32'd0);
        model_conflict();
        collect_and_check(tag);
    endtask

    task automatic both_pulse(input string tag);
        @(negedge clock);
        start    = 1'b1;
        conflict = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        conflict = 1'b0;
        model_conflict();
        collect_and_check(tag);
    endtask

    initial begin
        int r;
        model_clear();
        do_reset("por");

        decide(8'h04, 1'b1, 2);

        do_reset("t2");
        decide(8'h01, 1'b1, 32'($urandom_range(0, 3)));
        decide(8'h02, 1'b0, 32'($urandom_range(0, 3)));
        decide(8'h04, 1'b1, 32'($urandom_range(0, 3)));
        pulse_conflict("t2_conf");
        pulse_conflict("t3_conf");
        pulse_conflict("t4_conf_a");
        pulse_conflict("t4_conf_b");
        decide(8'h10, 1'b1, 1);
        pulse_conflict("t4_ignored");

        do_reset("t4d");
        pulse_conflict("t4_level0");

        do_reset("t5");
        decide(8'h20, 1'b0, 1);
        decide(8'h00, 1'b1, 1);
        decide(8'h40, 1'b1, 0);

        do_reset("t5_ovf");
        for (int i = 0; i < DEPTH + 1; i++)
            decide(8'h01 << (i % 8), 1'(i & 1), 32'($urandom_range(0, 2)));

        do_reset("t6");
        decide(8'h08, 1'b1, 0);
        decide(8'h40, 1'b0, 1);
        req_conflict("t6_fin", 1'b1, 8'h80);
        req_conflict("t6_nofin", 1'b0, 8'h00);
        both_pulse("t7_both");

        do_reset("t8");
        decide(8'h03, 1'b1, 1);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("mid_req_dec_en", 32'(decision_en), 32'd1);
        do_reset("t8_mid");
        check_status("t8_after");

        for (int i = 0; i < 150; i++) begin
            r = 32'($urandom_range(0, 19));
            if (m_done && r > 14)
                do_reset("rnd_rst");
            else if (r < 11)
                decide((r == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                       1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)));
            else if (r < 16)
                pulse_conflict("rnd_conf");
            else if (r < 18)
                req_conflict("rnd_req", 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)));
            else
                both_pulse("rnd_both");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
